frame_buffer_ctrl: RTL and testbench

//  Double-buffered 8-bit frame buffer sitting directly downstream of the draw engines (env/sprite/win

---
 rtl/frame_buffer_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - double-buffered 8-bit frame buffer, vblank-synchronised page flip
// Define FB_CLEAR_EN to sweep the new back page with CLEAR_COLOR after every flip.
module frame_buffer_ctrl #(
  parameter int         H_RES       = 320,
  parameter int         V_RES       = 240,
  parameter int         SCALE_SHIFT = 1,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       WE,
  input  logic [8:0] PIXEL_X,
  input  logic [8:0] PIXEL_Y,
  input  logic [7:0] PIXEL_DIN,
  input  logic       DRAW_DONE,
  input  logic [9:0] VGA_X,
  input  logic [9:0] VGA_Y,
  input  logic       VGA_BLANK,
  input  logic       RD_EN,
  output logic [7:0] PIXEL_OUT,
  output logic       PAGE_SEL,
  output logic       BUSY,
  output logic       FLIP_ACK,
  output logic [7:0] FRAME_CNT
);

  localparam int             DEPTH   = H_RES * V_RES;
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [9:0]     H_MAX   = 10'(H_RES);
  localparam logic [9:0]     V_MAX   = 10'(V_RES);

  typedef enum logic [1:0] {
    S_DRAW,
    S_PENDING,
    S_FLIP
`ifdef FB_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vblank_q;
  logic        vb_rise;

  // Page 0 occupies [0, DEPTH), page 1 occupies [DEPTH, 2*DEPTH).
  logic [7:0]  mem [0:2*DEPTH-1];

  function automatic logic [AW-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
    lin_addr = AW'(32'(y) * H_RES + 32'(x));
  endfunction

  function automatic logic [AW:0] page_idx(input logic pg, input logic [AW-1:0] a);
    page_idx = {1'b0, a} + (pg ? DEPTH_W : '0);
  endfunction

  assign vb_rise   = VGA_BLANK & ~vblank_q;
  assign PAGE_SEL  = page_q;
  assign FRAME_CNT = cnt_q;

`ifdef FB_CLEAR_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  logic [AW-1:0] clr_q, clr_d;
`endif

  // Control FSM
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q  <= S_DRAW;
      page_q   <= 1'b0;
      cnt_q    <= 8'd0;
      vblank_q <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      vblank_q <= VGA_BLANK;
`ifdef FB_CLEAR_EN
      clr_q    <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    BUSY     = 1'b0;
    FLIP_ACK = 1'b0;
`ifdef FB_CLEAR_EN
    clr_d    = clr_q;
`endif
    case (state_q)
      S_DRAW: begin
        if (DRAW_DONE && vb_rise) state_d = S_FLIP;
        else if (DRAW_DONE)       state_d = S_PENDING;
      end
      S_PENDING: begin
        if (vb_rise) state_d = S_FLIP;
      end
      S_FLIP: begin
        BUSY     = 1'b1;
        FLIP_ACK = 1'b1;
        page_d   = ~page_q;
        cnt_d    = cnt_q + 8'd1;
`ifdef FB_CLEAR_EN
        clr_d    = '0;
        state_d  = S_CLEAR;
`else
        state_d  = S_DRAW;
`endif
      end
`ifdef FB_CLEAR_EN
      S_CLEAR: begin
        BUSY  = 1'b1;
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST_ADDR) state_d = S_DRAW;
      end
`endif
      default: state_d = S_DRAW;
    endcase
  end

  // Single write port into the back page: engine writes or clear sweep
  logic          mem_we;
  logic [AW:0]   mem_wa;
  logic [7:0]    mem_wd;
  logic          wr_in_range;

  assign wr_in_range = ({1'b0, PIXEL_X} < H_MAX) && ({1'b0, PIXEL_Y} < V_MAX);

  always_comb begin
    mem_we = 1'b0;
    mem_wa = page_idx(~page_q, lin_addr({1'b0, PIXEL_X}, {1'b0, PIXEL_Y}));
    mem_wd = CLEAR_COLOR;
    if (!RESET) begin
      if ((state_q == S_DRAW || state_q == S_PENDING) && WE && wr_in_range) begin
        mem_we = 1'b1;
        mem_wd = PIXEL_DIN;
      end
`ifdef FB_CLEAR_EN
      if (state_q == S_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = page_idx(~page_q, clr_q);
      end
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Scanout: stage 1 registers address and page, stage 2 registers RAM data.
  // Latching the page in stage 1 lets in-flight reads finish on the old page.
  logic [9:0]  rx, ry;
  logic        rd_ok;
  logic [AW:0] rd_idx_q;
  logic        rd_ok_q, rd_ok2_q;
  logic [7:0]  ram_q;

  assign rx    = VGA_X >> SCALE_SHIFT;
  assign ry    = VGA_Y >> SCALE_SHIFT;
  assign rd_ok = RD_EN && (rx < H_MAX) && (ry < V_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rd_idx_q <= '0;
      rd_ok_q  <= 1'b0;
      rd_ok2_q <= 1'b0;
    end else begin
      rd_idx_q <= rd_ok ? page_idx(page_q, lin_addr(rx, ry)) : '0;
      rd_ok_q  <= rd_ok;
      rd_ok2_q <= rd_ok_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    ram_q <= mem[rd_idx_q];
  end

  assign PIXEL_OUT = rd_ok2_q ? ram_q : 8'h00;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb/tb_frame_buffer_ctrl.sv - randomized check of frame_buffer_ctrl against a page/pixel model
// Define FB_CLEAR_EN to run the small-frame clear configuration.
module tb_frame_buffer_ctrl;

`ifdef FB_CLEAR_EN
  localparam int         H = 8, V = 4, CLR = 1;
  localparam logic [7:0] COLOR = 8'h11;
`else
  localparam int         H = 320, V = 240, CLR = 0;
  localparam logic [7:0] COLOR = 8'h00;
`endif
  localparam int SS = 1;
  localparam int DEPTH = H * V;

  logic       CLOCK_50 = 1'b0;
  logic       RESET, WE, DRAW_DONE, VGA_BLANK, RD_EN;
  logic [8:0] PIXEL_X, PIXEL_Y;
  logic [7:0] PIXEL_DIN;
  logic [9:0] VGA_X, VGA_Y;
  logic [7:0] PIXEL_OUT, FRAME_CNT;
  logic       PAGE_SEL, BUSY, FLIP_ACK;

  frame_buffer_ctrl #(.H_RES(H), .V_RES(V), .SCALE_SHIFT(SS), .CLEAR_COLOR(COLOR)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .WE(WE), .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y),
    .PIXEL_DIN(PIXEL_DIN), .DRAW_DONE(DRAW_DONE), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .VGA_BLANK(VGA_BLANK), .RD_EN(RD_EN), .PIXEL_OUT(PIXEL_OUT), .PAGE_SEL(PAGE_SEL),
    .BUSY(BUSY), .FLIP_ACK(FLIP_ACK), .FRAME_CNT(FRAME_CNT)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: two byte pages, pending-frame flag, flip/clear timers
  logic [7:0] m_mem   [2*DEPTH];
  bit         m_known [2*DEPTH];
  int         m_page, m_cnt, m_clr;
  bit         m_wait, m_flip, m_vb;
  bit         p1_ok;
  int         p1_idx;
  logic [7:0] m_pix;
  bit         m_pix_known;
  int         busy_len;

  function automatic bit m_busy();
    return m_flip || (m_clr > 0);
  endfunction

  task automatic model_edge();
    int widx, rx, ry;
    bit vbr;
    if (RESET) begin
      m_page = 0; m_cnt = 0; m_clr = 0; m_wait = 0; m_flip = 0; m_vb = 0;
      p1_ok = 0; m_pix = 8'h00; m_pix_known = 1;
    end else begin
      if (p1_ok) begin
        m_pix = m_mem[p1_idx]; m_pix_known = m_known[p1_idx];
      end else begin
        m_pix = 8'h00; m_pix_known = 1;
      end
      if (!m_busy() && WE && int'(PIXEL_X) < H && int'(PIXEL_Y) < V) begin
        widx = (1 - m_page) * DEPTH + int'(PIXEL_Y) * H + int'(PIXEL_X);
        m_mem[widx] = PIXEL_DIN; m_known[widx] = 1;
      end
      if (m_clr > 0) begin
        widx = (1 - m_page) * DEPTH + (DEPTH - m_clr);
        m_mem[widx] = COLOR; m_known[widx] = 1;
      end
      rx = int'(VGA_X) >> SS;
      ry = int'(VGA_Y) >> SS;
      p1_ok  = RD_EN && rx < H && ry < V;
      p1_idx = m_page * DEPTH + ry * H + rx;
      vbr  = VGA_BLANK && !m_vb;
      m_vb = VGA_BLANK;
      if (m_flip) begin
        m_page = 1 - m_page; m_cnt = (m_cnt + 1) % 256; m_flip = 0;
        m_clr  = CLR ? DEPTH : 0;
      end else if (m_clr > 0) begin
        m_clr--;
      end else if (vbr && (m_wait || DRAW_DONE)) begin
        m_flip = 1; m_wait = 0;
      end else if (DRAW_DONE) begin
        m_wait = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    chk("page", PAGE_SEL, m_page);
    chk("fcnt", FRAME_CNT, m_cnt);
    chk("busy", BUSY, m_busy());
    chk("ack", FLIP_ACK, m_flip);
    if (m_pix_known) chk("pix", PIXEL_OUT, m_pix);
  endtask

  task automatic wait_idle();
    busy_len = 0;
    for (int i = 0; i < DEPTH + 8 && m_busy(); i++) begin
      if (BUSY) busy_len++;
      step();
    end
    chk("idle_busy", BUSY, 0);
  endtask

  task automatic do_flip();
    VGA_BLANK = 0; DRAW_DONE = 0;
    step();
    DRAW_DONE = 1; VGA_BLANK = 1;
    step();
    DRAW_DONE = 0; VGA_BLANK = 0;
    wait_idle();
  endtask

  function automatic logic [9:0] rc(input int lim);
    if ($urandom_range(0, 1) != 0) return 10'($urandom_range(0, 3));
    return 10'($urandom_range(lim - 3, lim + 1));
  endfunction

  initial begin
    RESET = 1; WE = 0; DRAW_DONE = 0; VGA_BLANK = 0; RD_EN = 0;
    PIXEL_X = 0; PIXEL_Y = 0; PIXEL_DIN = 0; VGA_X = 0; VGA_Y = 0;
    step(); step();
    RESET = 0;

    // Write, frame-done then vblank, read back through the 2x scanout
    WE = 1; PIXEL_X = 9'd5; PIXEL_Y = 9'd7; PIXEL_DIN = 8'hA3;
    step();
    WE = 0; DRAW_DONE = 1;
    step();
    DRAW_DONE = 0; VGA_BLANK = 1;
    step();
    chk("t1_ack", FLIP_ACK, 1);
    wait_idle();
    VGA_X = 10'd10; VGA_Y = 10'd14; RD_EN = 1;
    step(); step();
`ifndef FB_CLEAR_EN
    chk("t1_pix", PIXEL_OUT, 8'hA3);
`endif

    // Out-of-range writes must not disturb the edge pixels
    WE = 1; PIXEL_DIN = 8'h5A;
    PIXEL_X = 9'(H - 1); PIXEL_Y = 0; step();
    PIXEL_X = 0; PIXEL_Y = 9'(V - 1); step();
    PIXEL_DIN = 8'hFF;
    PIXEL_X = 9'(H); PIXEL_Y = 0; step();
    PIXEL_X = 0; PIXEL_Y = 9'(V); step();
    WE = 0;
    do_flip();
    VGA_X = 10'((H - 1) << SS); VGA_Y = 0; RD_EN = 1;
    step(); step();
    chk("t2_xedge", PIXEL_OUT, 8'h5A);
    VGA_X = 0; VGA_Y = 10'((V - 1) << SS);
    step(); step();
    chk("t2_yedge", PIXEL_OUT, 8'h5A);

    // Frame-done 50 cycles before the vblank rise
    RESET = 1; step(); RESET = 0;
    VGA_BLANK = 0; DRAW_DONE = 1;
    step();
    DRAW_DONE = 0;
    repeat (49) step();
    VGA_BLANK = 1;
    step();
    chk("t3_ack", FLIP_ACK, 1);
    step();
    chk("t3_page", PAGE_SEL, 1);
    chk("t3_cnt", FRAME_CNT, 1);
    wait_idle();

    // 256 flips wrap the frame counter
    RESET = 1; step(); RESET = 0;
    do_flip();
    chk("busy_len", busy_len, 1 + CLR * DEPTH);
    repeat (255) do_flip();
    chk("t4_wrap", FRAME_CNT, 0);

    // Scanout gated by RD_EN; reset while pending
    RD_EN = 0;
    step(); step();
    chk("t5_rd0", PIXEL_OUT, 0);
    do_flip();
    DRAW_DONE = 1; step();
    DRAW_DONE = 0; step();
    RESET = 1; step(); RESET = 0;
    chk("t5_page", PAGE_SEL, 0);
    step();
    VGA_BLANK = 1; step(); step();
    chk("t5_noflip", FLIP_ACK, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      RESET     = ($urandom_range(0, 999) == 0);
      WE        = $urandom_range(0, 1);
      PIXEL_X   = 9'(rc(H));
      PIXEL_Y   = 9'(rc(V));
      PIXEL_DIN = 8'($urandom);
      DRAW_DONE = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) VGA_BLANK = ~VGA_BLANK;
      RD_EN     = ($urandom_range(0, 3) != 0);
      VGA_X     = 10'((rc(H) << SS) | 10'($urandom_range(0, 1)));
      VGA_Y     = 10'((rc(V) << SS) | 10'($urandom_range(0, 1)));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
